// File: rtl/hilo_muldiv_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: op encodings,
// FSM states and a constant-width helper.
package hilo_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MADD  = 3'b010;
  localparam logic [2:0] OP_MSUB  = 3'b011;
  localparam logic [2:0] OP_DIV   = 3'b100;
  localparam logic [2:0] OP_DIVU  = 3'b101;
  localparam logic [2:0] OP_MTHI  = 3'b110;
  localparam logic [2:0] OP_MTLO  = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/hilo_muldiv_unit_iter_core.sv
// One-bit-per-cycle datapath shared by multiply (shift-add) and divide
// (restoring); works on unsigned magnitudes only.
module hilo_iter_core
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_load,
  input  logic                 i_step,
  input  logic                 i_div,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic [2*WIDTH-1:0]   o_acc,
  output logic                 o_last
);

  localparam int CNT_W = clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_b;
  logic               r_div;
  logic [CNT_W-1:0]   r_cnt;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_shift;
  logic               w_fits;
  logic [WIDTH-1:0]   w_rem_sub;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [2*WIDTH-1:0] w_div_next;

  // Multiply: upper half collects partial sums, multiplier shifts out of the
  // bottom. Divide: remainder in the upper half, quotient bits shift in below.
  always_comb begin
    w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
    w_mul_next = {w_sum, r_acc[WIDTH-1:1]};
    w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_fits     = (w_shift >= {1'b0, r_b});
    w_rem_sub  = WIDTH'(w_shift - {1'b0, r_b});
    w_div_next = {(w_fits ? w_rem_sub : w_shift[WIDTH-1:0]), r_acc[WIDTH-2:0], w_fits};
  end

  // NOTE: the accumulator is pure datapath, always loaded before it is read,
  // so it carries no reset; only control state is reset.
  always_ff @(posedge i_clk) begin
    if (i_load) begin
      r_acc <= {{WIDTH{1'b0}}, i_a};
      r_b   <= i_b;
      r_div <= i_div;
    end else if (i_step) begin
      r_acc <= r_div ? w_div_next : w_mul_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(WIDTH);
    end else if (i_step) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_acc  = r_acc;
  assign o_last = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with iterative MULT/MULTU/MADD/MSUB/DIV/DIVU and
// direct MTHI/MTLO writes, under a start/busy/done handshake.
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Flush,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  state_t r_state;
  state_t w_state_next;

  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic             r_b_zero;
  logic             r_neg_q;
  logic             r_neg_r;

  logic               w_accept;
  logic               w_is_mt;
  logic               w_signed;
  logic               w_load;
  logic               w_step;
  logic               w_write;
  logic               w_last;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [2*WIDTH-1:0] w_acc;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_hilo_new;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_is_mt  = (Op == OP_MTHI) || (Op == OP_MTLO);
  assign w_signed = (Op == OP_MULT) || (Op == OP_MADD) || (Op == OP_MSUB) || (Op == OP_DIV);
  assign w_a_mag  = (w_signed && A[WIDTH-1]) ? -A : A;
  assign w_b_mag  = (w_signed && B[WIDTH-1]) ? -B : B;

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (Start && !Flush) begin
          w_accept = 1'b1;
          if (!w_is_mt) w_state_next = RUN;
        end
      end
      RUN: begin
        if (Flush)       w_state_next = IDLE;
        else if (w_last) w_state_next = FINISH;
      end
      FINISH:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_load  = w_accept && !w_is_mt;
  assign w_step  = (r_state == RUN) && !Flush;
  assign w_write = (r_state == FINISH) && !Flush;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != IDLE);
    end
  end

  always_ff @(posedge Clk) begin
    if (w_load) begin
      r_op     <= Op;
      r_a      <= A;
      r_b_zero <= (B == '0);
      r_neg_q  <= w_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
      r_neg_r  <= w_signed && A[WIDTH-1];
    end
  end

  hilo_iter_core #(.WIDTH(WIDTH)) u_core (
    .i_clk   (Clk),
    .i_rst_n (Rst),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_div   (Op[2]),
    .i_a     (w_a_mag),
    .i_b     (w_b_mag),
    .o_acc   (w_acc),
    .o_last  (w_last)
  );

  // Sign correction and accumulate; divide-by-zero is forced so signed and
  // unsigned divides report the same all-ones quotient and raw dividend.
  always_comb begin
    w_prod     = r_neg_q ? -w_acc : w_acc;
    w_quo      = r_neg_q ? -w_acc[WIDTH-1:0] : w_acc[WIDTH-1:0];
    w_rem      = r_neg_r ? -w_acc[2*WIDTH-1:WIDTH] : w_acc[2*WIDTH-1:WIDTH];
    w_hilo_new = w_prod;
    case (r_op)
      OP_MADD: w_hilo_new = {r_hi, r_lo} + w_prod;
      OP_MSUB: w_hilo_new = {r_hi, r_lo} - w_prod;
      OP_DIV, OP_DIVU: begin
        if (r_b_zero) w_hilo_new = {r_a, {WIDTH{1'b1}}};
        else          w_hilo_new = {w_rem, w_quo};
      end
      default: w_hilo_new = w_prod;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept && (Op == OP_MTHI)) begin
        r_hi   <= A;
        r_done <= 1'b1;
      end
      if (w_accept && (Op == OP_MTLO)) begin
        r_lo   <= A;
        r_done <= 1'b1;
      end
      if (w_write) begin
        r_hi   <= w_hilo_new[2*WIDTH-1:WIDTH];
        r_lo   <= w_hilo_new[WIDTH-1:0];
        r_done <= 1'b1;
      end
    end
  end

  assign Busy = r_busy;
  assign Done = r_done;
  assign HI   = r_hi;
  assign LO   = r_lo;

endmodule
